// File: rtl/fwd_bypass_net.sv
// fwd_bypass_net: operand-forwarding network with a DEPTH-entry shift history
// of in-flight register writes, youngest-match resolution per read port and
// load-use stall detection.
module fwd_bypass_net #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned NRD    = 2,
   parameter int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic                  flush,
   input  logic                  wr_valid,
   input  logic [REG_AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  wr_rdy,
   input  logic                  fill_valid,
   input  logic [DATA_W-1:0]     fill_data,
   input  logic [NRD*REG_AW-1:0] rd_addr,
   input  logic [NRD*DATA_W-1:0] rd_rf_data,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD*SEL_W-1:0]  rd_sel,
   output logic                  stall_req
);

   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0]             rdy_q,   rdy_d;
   logic [DEPTH-1:0][REG_AW-1:0] addr_q,  addr_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;

   logic              fill_hit;
   logic [DATA_W-1:0] fill_data1;
   logic              fill_rdy1;

   // History register; asynchronous reset clears every field
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         rdy_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         rdy_q   <= rdy_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Next history: flush > hold (fill in place) > shift (fill travels to index 2)
   always_comb begin
      valid_d = valid_q;
      rdy_d   = rdy_q;
      addr_d  = addr_q;
      data_d  = data_q;

      fill_hit   = fill_valid && valid_q[1] && !rdy_q[1];
      fill_data1 = fill_hit ? fill_data : data_q[1];
      fill_rdy1  = rdy_q[1] | fill_hit;

      if (flush) begin
         valid_d = '0;
      end else if (hold) begin
         data_d[1] = fill_data1;
         rdy_d[1]  = fill_rdy1;
      end else begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
            // entry 1 may be completed by a fill on this same edge
            data_d[i]  = (i == 2) ? fill_data1 : data_q[i-1];
            rdy_d[i]   = (i == 2) ? fill_rdy1  : rdy_q[i-1];
         end
         valid_d[0] = wr_valid && (wr_addr != '0);
         addr_d[0]  = wr_addr;
         data_d[0]  = wr_data;
         rdy_d[0]   = wr_rdy;
      end
   end

   // Per-port resolution against the youngest matching valid entry
   always_comb begin
      logic              hit;
      logic [REG_AW-1:0] ra;
      rd_data   = '0;
      rd_sel    = '0;
      stall_req = 1'b0;
      for (int unsigned p = 0; p < NRD; p++) begin
         hit = 1'b0;
         ra  = rd_addr[p*REG_AW +: REG_AW];
         rd_data[p*DATA_W +: DATA_W] = rd_rf_data[p*DATA_W +: DATA_W];
         rd_sel[p*SEL_W +: SEL_W]    = '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit && valid_q[i] && (ra != '0) && (addr_q[i] == ra)) begin
               hit = 1'b1;
               rd_sel[p*SEL_W +: SEL_W]    = SEL_W'(i + 1);
               rd_data[p*DATA_W +: DATA_W] = data_q[i];
               if (!rdy_q[i]) stall_req = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fwd_bypass_net.sv
// tb_fwd_bypass_net: directed table-driven bench for fwd_bypass_net plus
// hand-written load-use, flush-priority and asynchronous-reset sequences.
module tb_fwd_bypass_net;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned DEPTH  = 3;
   localparam int unsigned NRD    = 2;
   localparam int unsigned SEL_W  = 2;

   localparam logic [31:0] RF0 = 32'h1111;
   localparam logic [31:0] RF1 = 32'h2222;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  hold, flush, wr_valid, wr_rdy, fill_valid;
   logic [REG_AW-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data, fill_data;
   logic [NRD*REG_AW-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_rf_data;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD*SEL_W-1:0]  rd_sel;
   logic                  stall_req;

   int n_checks = 0;
   int n_fail   = 0;

   fwd_bypass_net #(
      .DATA_W(DATA_W),
      .REG_AW(REG_AW),
      .DEPTH (DEPTH),
      .NRD   (NRD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .flush     (flush),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_rdy    (wr_rdy),
      .fill_valid(fill_valid),
      .fill_data (fill_data),
      .rd_addr   (rd_addr),
      .rd_rf_data(rd_rf_data),
      .rd_data   (rd_data),
      .rd_sel    (rd_sel),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              hold, flush, wv, wrdy, fv;
      logic [REG_AW-1:0] wa, ra0, ra1;
      logic [31:0]       wd, fd, ed0, ed1;
      logic [1:0]        es0, es1;
      logic              est;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic h, input logic f, input logic wv,
                      input logic [4:0] wa, input logic [31:0] wd, input logic wrdy,
                      input logic fv, input logic [31:0] fd,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [1:0] es0, input logic [1:0] es1,
                      input logic [31:0] ed0, input logic [31:0] ed1,
                      input logic est);
      vec_t v;
      v.hold = h; v.flush = f; v.wv = wv; v.wa = wa; v.wd = wd; v.wrdy = wrdy;
      v.fv = fv; v.fd = fd; v.ra0 = ra0; v.ra1 = ra1;
      v.es0 = es0; v.es1 = es1; v.ed0 = ed0; v.ed1 = ed1; v.est = est;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ports(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                            input logic [31:0] d0, input logic [31:0] d1, input logic st);
      chk({tag, ".sel0"},  64'(rd_sel[0 +: SEL_W]),  64'(s0));
      chk({tag, ".sel1"},  64'(rd_sel[SEL_W +: SEL_W]), 64'(s1));
      chk({tag, ".data0"}, 64'(rd_data[0 +: DATA_W]), 64'(d0));
      chk({tag, ".data1"}, 64'(rd_data[DATA_W +: DATA_W]), 64'(d1));
      chk({tag, ".stall"}, 64'(stall_req), 64'(st));
   endtask

   task automatic idle();
      hold = 0; flush = 0; wr_valid = 0; wr_addr = '0; wr_data = '0; wr_rdy = 1;
      fill_valid = 0; fill_data = '0;
   endtask

   task automatic drive_wr(input logic [4:0] a, input logic [31:0] d, input logic r);
      wr_valid = 1; wr_addr = a; wr_data = d; wr_rdy = r;
   endtask

   initial begin
      // hold ef: h  f  wv wa  wd            wrdy fv fd            ra0 ra1 s0 s1 d0            d1            st
      add(0, 0, 1, 5,  32'hA,        1, 0, 32'h0,        5,  3,  0, 0, RF0,          RF1,          0);
      add(0, 0, 1, 5,  32'hB,        1, 0, 32'h0,        5,  0,  1, 0, 32'hA,        RF1,          0);
      add(0, 0, 0, 0,  32'h0,        1, 0, 32'h0,        5,  5,  1, 1, 32'hB,        32'hB,        0);
      add(0, 0, 0, 0,  32'h0,        1, 0, 32'h0,        5,  5,  2, 2, 32'hB,        32'hB,        0);
      add(0, 0, 0, 0,  32'h0,        1, 0, 32'h0,        5,  5,  3, 3, 32'hB,        32'hB,        0);
      add(0, 0, 1, 0,  32'hFFFF,     1, 0, 32'h0,        5,  5,  0, 0, RF0,          RF1,          0);
      add(0, 0, 1, 3,  32'h33,       1, 0, 32'h0,        0,  0,  0, 0, RF0,          RF1,          0);
      add(0, 0, 1, 4,  32'hDEAD,     0, 0, 32'h0,        3,  4,  1, 0, 32'h33,       RF1,          0);
      add(1, 0, 1, 9,  32'h99,       1, 1, 32'hBAD,      3,  4,  2, 1, 32'h33,       32'hDEAD,     1);
      add(0, 0, 0, 0,  32'h0,        1, 0, 32'h0,        3,  4,  2, 1, 32'h33,       32'hDEAD,     1);
      add(1, 0, 0, 0,  32'h0,        1, 1, 32'hCAFE,     4,  3,  2, 3, 32'hDEAD,     32'h33,       1);
      add(0, 0, 0, 0,  32'h0,        1, 0, 32'h0,        4,  3,  2, 3, 32'hCAFE,     32'h33,       0);
      add(0, 0, 0, 0,  32'h0,        1, 1, 32'h1234,     4,  9,  3, 0, 32'hCAFE,     RF1,          0);

      idle();
      rst = 1;
      rd_addr = {5'd5, 5'd5};
      rd_rf_data = {RF1, RF0};
      #2;
      chk_ports("reset", 0, 0, RF0, RF1, 0);
      @(negedge clk);
      rst = 0;

      // table-driven: outputs checked before the edge that applies the vector's writes
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         hold = vecs[k].hold; flush = vecs[k].flush;
         wr_valid = vecs[k].wv; wr_addr = vecs[k].wa; wr_data = vecs[k].wd; wr_rdy = vecs[k].wrdy;
         fill_valid = vecs[k].fv; fill_data = vecs[k].fd;
         rd_addr = {vecs[k].ra1, vecs[k].ra0};
         rd_rf_data = {RF1, RF0};
         #1;
         chk_ports($sformatf("vec%0d", k), vecs[k].es0, vecs[k].es1,
                   vecs[k].ed0, vecs[k].ed1, vecs[k].est);
      end

      // load-use with hold driven from stall_req
      @(negedge clk); idle(); drive_wr(7, 32'h0, 0); rd_addr = {5'd0, 5'd0};
      @(negedge clk); idle(); #1; hold = stall_req;
      chk("lu.nostall_idx0_unread", 64'(stall_req), 64'(0));
      @(negedge clk); idle(); rd_addr = {5'd0, 5'd7}; #1;
      chk("lu.stall", 64'(stall_req), 64'(1));
      chk("lu.sel_before", 64'(rd_sel[0 +: SEL_W]), 64'(2));
      hold = stall_req; fill_valid = 1; fill_data = 32'hCAFE;
      @(negedge clk); idle(); #1; hold = stall_req;
      chk("lu.stall_clear", 64'(stall_req), 64'(0));
      chk("lu.data", 64'(rd_data[0 +: DATA_W]), 64'(32'hCAFE));
      chk("lu.sel_after", 64'(rd_sel[0 +: SEL_W]), 64'(2));

      // flush beats hold, fill and write on the same edge
      @(negedge clk); idle(); drive_wr(6, 32'h66, 1);
      @(negedge clk); idle(); drive_wr(8, 32'h88, 0);
      @(negedge clk); idle(); rd_addr = {5'd6, 5'd8}; #1;
      chk_ports("fl.pre", 1, 2, 32'h88, 32'h66, 1);
      flush = 1; hold = 1; fill_valid = 1; fill_data = 32'h5A5A; drive_wr(8, 32'h77, 1);
      @(negedge clk); idle(); #1;
      chk_ports("fl.post", 0, 0, RF0, RF1, 0);

      // asynchronous reset mid-operation
      @(negedge clk); idle(); drive_wr(1, 32'h10, 0);
      @(negedge clk); idle(); drive_wr(2, 32'h20, 1);
      @(negedge clk); idle(); drive_wr(3, 32'h30, 1);
      @(negedge clk); idle(); rd_addr = {5'd2, 5'd1}; #1;
      chk_ports("rs.pre", 3, 2, 32'h10, 32'h20, 1);
      #2 rst = 1;
      #1;
      chk_ports("rs.async", 0, 0, RF0, RF1, 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      chk_ports("rs.post", 0, 0, RF0, RF1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fwd_bypass_net.md
# fwd_bypass_net

Parametrised operand-forwarding network for the pipelined datapath. It supersedes the fixed 4:1 operand-forward selector with a self-tracking bypass store. The block keeps a shift history of the last DEPTH register writes in flight, resolves every read port against the youngest matching producer, and raises a stall request when that producer's data is not yet available (load-use). It sits between the register-file read stage and the execute stage, one instance per issue slot.

## Interface
Parameters:
- DATA_W, 32, operand width
- REG_AW, 5, register address width
- DEPTH, 3, in-flight producer entries tracked (≥2)
- NRD, 2, number of read ports
- SEL_W, $clog2(DEPTH+1), width of each source-select code

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- hold  in  1  freeze the history (pipeline stall)
- flush  in  1  invalidate all entries (branch/jump squash)
- wr_valid  in  1  new producer enters entry 0
- wr_addr  in  REG_AW  producer destination register
- wr_data  in  DATA_W  producer result, meaningful when wr_rdy=1
- wr_rdy  in  1  result available now; 0 = load, data arrives via fill
- fill_valid  in  1  late (memory) data for the entry currently at index 1
- fill_data  in  DATA_W  late data
- rd_addr  in  NRD*REG_AW  source register per port, port p at [p*REG_AW +: REG_AW]
- rd_rf_data  in  NRD*DATA_W  register-file value per port
- rd_data  out  NRD*DATA_W  resolved operand per port
- rd_sel  out  NRD*SEL_W  source per port: 0 = register file, i+1 = entry i
- stall_req  out  1  some port needs an entry whose data is not ready

## Operation
- Each entry i (0 = youngest) holds valid, addr, data and rdy.
- Edge with flush=1: all valid←0. Flush has priority over hold, fill and write.
- Edge with hold=1 (flush=0): entries unchanged, wr_* ignored, fill still applied to entry 1 in place.
- Edge with hold=0, flush=0:
  - Entry i+1 ← entry i. Entry DEPTH-1 is discarded.
  - Entry 0 ← {wr_valid && wr_addr≠0, wr_addr, wr_data, wr_rdy}.
- Fill: if fill_valid, entry 1 valid and entry 1 !rdy, then the entry's data ← fill_data and rdy←1. The filled value travels with the entry, landing at index 2 when advancing.
- fill_valid on an entry that is not valid, or is already rdy: ignored.
- Resolution, per port p, combinational on current state:
  - Find the lowest i with valid_i and addr_i == rd_addr_p.
  - Address 0 never matches.
  - Match found: rd_sel_p = i+1 and rd_data_p = data_i.
  - No match: rd_sel_p = 0 and rd_data_p = rd_rf_data_p.
- stall_req = OR over ports of (match found && !rdy of the matched entry).
  - An older ready entry for the same address never masks a younger unready one.
- Same address in several entries: the youngest wins.
- Data of invalid entries is don't-care but never selected.

## Timing
- Reset (asynchronous assert): all valid←0, rdy←0, data←0, addr←0. Immediately rd_sel=0, rd_data=rd_rf_data and stall_req=0. Release is synchronous to clk.
- Read resolution and stall_req are zero-latency combinational paths from rd_addr, rd_rf_data and the entry state. There is no combinational path from wr_* or fill_* to the outputs.
- A write accepted on edge N is forwardable from just after edge N, for DEPTH cycles of hold=0.
- A load entering at edge N with wr_rdy=0:
  - Raises stall_req for a matching reader in the cycle after N.
  - Fill arrives in the cycle after edge N+1, when the entry sits at index 1.
  - stall_req clears after that fill edge.
- Environment rule: it drives hold=stall_req, so a stalled load stays at index 1 until filled.

## Test plan
- Reset mid-operation: load 3 entries, assert rst asynchronously. Same cycle: rd_sel=0, stall_req=0. After release, rd_data equals rd_rf_data=32'h1111.
- Youngest wins: write r5=0xA, then r5=0xB, hold=0. Port 0 reads r5 → rd_sel=1, rd_data=0xB. One cycle later → rd_sel=2, 0xB. After DEPTH cycles with no writes → rd_sel=0.
- $zero: write r0=0xFFFF. Reads of r0 → rd_sel=0, rd_data=rd_rf_data.
- Load-use: write r7 with wr_rdy=0, read r7 → stall_req=1 with hold tied to stall_req. Fill 0xCAFE → next cycle stall_req=0, rd_data=0xCAFE, rd_sel=2.
- Flush priority: flush, hold, fill and wr_valid all asserted on one edge → next cycle all ports rd_sel=0, stall_req=0.
- Dual port, NRD=2: port 0 r3 (entry 1, ready, 0x33) and port 1 r4 (entry 0, unready) → rd_sel = {1, 2}, stall_req=1, port 0 data 0x33.
